// File: rtl/keystream8_gen_pkg.sv
// Shared definitions for the 8-bit keystream generator: FSM encoding,
// LFSR width, default feedback mask and the zero-seed substitute.
package keystream8_gen_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_POLY  = 8'hB8;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/keystream8_gen_lfsr8_step.sv
// One Galois LFSR step: shift right, fold the feedback mask in when the
// bit shifted out was set.
module lfsr8_step
  import keystream8_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  logic [LFSR_W-1:0] shifted_s;

  assign shifted_s = {1'b0, cur[LFSR_W-1:1]};
  assign nxt       = cur[0] ? (shifted_s ^ POLY) : shifted_s;

endmodule

// File: rtl/keystream8_gen.sv
// Burst keystream source: emits LFSR bytes under a valid/ready handshake
// for a programmed byte count, with abort and a one-cycle done pulse.
module keystream8_gen
  import keystream8_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              seed_load,
  input  logic [7:0]        len_in,
  input  logic              start,
  input  logic              stop,
  input  logic              key_ready,
  output logic [LFSR_W-1:0] key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              done,
  output logic [8:0]        remaining
);

  state_e            state_r, state_s;
  logic [LFSR_W-1:0] lfsr_r, lfsr_s, step_s;
  logic [8:0]        rem_r, rem_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              xfer_s;

  lfsr8_step #(.POLY(POLY)) u_step (
    .cur (lfsr_r),
    .nxt (step_s)
  );

  assign xfer_s = valid_r & key_ready;

  // Next-state and next-output logic for the burst FSM
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_r;
    rem_s   = rem_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_s = (seed_in == 8'h00) ? ZERO_SEED_SUB : seed_in;
        end else begin
          lfsr_s = lfsr_r;
        end
        if (start) begin
          rem_s   = (len_in == 8'h00) ? 9'd256 : {1'b0, len_in};
          state_s = ST_RUN;
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          lfsr_s = step_s;
          rem_s  = rem_r - 9'd1;
        end else begin
          lfsr_s = lfsr_r;
          rem_s  = rem_r;
        end
        // A stop still lets a same-cycle transfer complete; remaining then freezes
        if (stop || (xfer_s && (rem_r == 9'd1))) begin
          state_s = ST_DONE;
          valid_s = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      lfsr_r  <= ZERO_SEED_SUB;
      rem_r   <= 9'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      lfsr_r  <= lfsr_s;
      rem_r   <= rem_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign key_out   = lfsr_r;
  assign key_valid = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = rem_r;

endmodule
